// File: rtl/expr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : expr_pkg
//  Brief    : Shared types and ASCII constants for the expression evaluator.
//             Optional subtraction support is controlled by EXPR_SUB_EN.
//  Revision : 1.0  initial release
// ============================================================================
package expr_pkg;

   // FSM states of the evaluator
   typedef enum logic [1:0] {
      S_OPND = 2'd0,   // expecting a digit
      S_OPTR = 2'd1,   // expecting an operator
      S_ERR  = 2'd2    // syntax error seen, waiting for '='
   } state_t;

   // Decoded character classes
   typedef enum logic [2:0] {
      C_DIGIT = 3'd0,
      C_ADD   = 3'd1,
      C_MUL   = 3'd2,
      C_SUB   = 3'd3,
      C_EQ    = 3'd4,
      C_BAD   = 3'd5
   } char_class_t;

   // ASCII codes of the recognised characters
   localparam logic [7:0] C_ASCII_ZERO  = 8'h30;  // '0'
   localparam logic [7:0] C_ASCII_NINE  = 8'h39;  // '9'
   localparam logic [7:0] C_ASCII_PLUS  = 8'h2B;  // '+'
   localparam logic [7:0] C_ASCII_STAR  = 8'h2A;  // '*'
   localparam logic [7:0] C_ASCII_MINUS = 8'h2D;  // '-'
   localparam logic [7:0] C_ASCII_EQ    = 8'h3D;  // '='

endpackage
`default_nettype wire

// File: rtl/expr_char_class.sv
`default_nettype none
// ============================================================================
//  Module   : expr_char_class
//  Brief    : Combinational decoder from an ASCII byte to a character class
//             and a 4-bit digit value. C_SUB is only produced when
//             EXPR_SUB_EN is defined; otherwise '-' decodes as C_BAD.
//  Revision : 1.0  initial release
// ============================================================================
module expr_char_class
   import expr_pkg::*;
(
   input  logic [7:0]  in,
   output char_class_t cls,
   output logic [3:0]  digit
);

   // Classify the byte; digit is only meaningful when cls == C_DIGIT
   always_comb begin
      cls   = C_BAD;
      // '0'..'9' are 8'h30..8'h39, so the low nibble is already in - '0'
      digit = in[3:0];
      if ((in >= C_ASCII_ZERO) && (in <= C_ASCII_NINE)) begin
         cls = C_DIGIT;
      end else begin
         case (in)
            C_ASCII_PLUS:  cls = C_ADD;
            C_ASCII_STAR:  cls = C_MUL;
            C_ASCII_EQ:    cls = C_EQ;
`ifdef EXPR_SUB_EN
            C_ASCII_MINUS: cls = C_SUB;
`endif
            default:       cls = C_BAD;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/expr_eval.sv
`default_nettype none
// ============================================================================
//  Module   : expr_eval
//  Brief    : Evaluates a stream of single-digit ASCII operands with '+' and
//             '*' ('*' binds tighter), terminated by '='. Produces a
//             registered result, a one-cycle done strobe and an error flag.
//             Define EXPR_SUB_EN to accept '-' as a binary operator.
//  Revision : 1.0  initial release
// ============================================================================
module expr_eval
   import expr_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             clr,
   input  logic             in_vld,
   input  logic [7:0]       in,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             err
);

   char_class_t      w_cls;
   logic [3:0]       w_digit;
   logic [WIDTH-1:0] w_digit_ext;
   logic [WIDTH-1:0] w_term;
   logic [WIDTH-1:0] w_total;

   state_t           r_state;
   logic [WIDTH-1:0] r_sum;    // completed terms
   logic [WIDTH-1:0] r_prod;   // current term (magnitude)
   logic             r_mul;    // next digit multiplies into r_prod
`ifdef EXPR_SUB_EN
   logic             r_neg;    // current term is subtracted
`endif

   expr_char_class u_char_class (
      .in    (in),
      .cls   (w_cls),
      .digit (w_digit)
   );

   assign w_digit_ext = WIDTH'(w_digit);

   // Signed value of the current term and the running total including it
   always_comb begin
`ifdef EXPR_SUB_EN
      w_term = r_neg ? (~r_prod + 1'b1) : r_prod;
`else
      w_term = r_prod;
`endif
      w_total = r_sum + w_term;
   end

   // Evaluator FSM, accumulators and registered outputs
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= S_OPND;
         r_sum   <= '0;
         r_prod  <= '0;
         r_mul   <= 1'b0;
`ifdef EXPR_SUB_EN
         r_neg   <= 1'b0;
`endif
         result  <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         // strobes last exactly one cycle, bubbles included
         done <= 1'b0;
         err  <= 1'b0;
         if (in_vld) begin
            case (r_state)
               S_OPND: begin
                  if (w_cls == C_DIGIT) begin
                     r_prod  <= r_mul ? (r_prod * w_digit_ext) : w_digit_ext;
                     r_state <= S_OPTR;
                  end else if (w_cls == C_EQ) begin
                     // empty expression or trailing operator
                     done    <= 1'b1;
                     err     <= 1'b1;
                     r_sum   <= '0;
                     r_prod  <= '0;
                     r_mul   <= 1'b0;
`ifdef EXPR_SUB_EN
                     r_neg   <= 1'b0;
`endif
                     r_state <= S_OPND;
                  end else begin
                     r_state <= S_ERR;
                  end
               end
               S_OPTR: begin
                  case (w_cls)
                     C_MUL: begin
                        r_mul   <= 1'b1;
                        r_state <= S_OPND;
                     end
                     C_ADD: begin
                        r_sum   <= w_total;
                        r_mul   <= 1'b0;
`ifdef EXPR_SUB_EN
                        r_neg   <= 1'b0;
`endif
                        r_state <= S_OPND;
                     end
`ifdef EXPR_SUB_EN
                     C_SUB: begin
                        r_sum   <= w_total;
                        r_mul   <= 1'b0;
                        r_neg   <= 1'b1;
                        r_state <= S_OPND;
                     end
`endif
                     C_EQ: begin
                        result  <= w_total;
                        done    <= 1'b1;
                        r_sum   <= '0;
                        r_prod  <= '0;
                        r_mul   <= 1'b0;
`ifdef EXPR_SUB_EN
                        r_neg   <= 1'b0;
`endif
                        r_state <= S_OPND;
                     end
                     default: r_state <= S_ERR;
                  endcase
               end
               S_ERR: begin
                  // everything but '=' is swallowed; result is left untouched
                  if (w_cls == C_EQ) begin
                     done    <= 1'b1;
                     err     <= 1'b1;
                     r_sum   <= '0;
                     r_prod  <= '0;
                     r_mul   <= 1'b0;
`ifdef EXPR_SUB_EN
                     r_neg   <= 1'b0;
`endif
                     r_state <= S_OPND;
                  end
               end
               default: r_state <= S_OPND;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_expr_eval.sv
`default_nettype none
// ============================================================================
//  Module   : tb_expr_eval
//  Brief    : Directed self-checking bench for expr_eval. A 16-bit and an
//             8-bit instance receive the same character stream.
//             Expectations for '-' depend on EXPR_SUB_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_expr_eval;

   logic        clk;
   logic        clr;
   logic        in_vld;
   logic [7:0]  in_ch;
   logic [15:0] result16;
   logic        done16;
   logic        err16;
   logic [7:0]  result8;
   logic        done8;
   logic        err8;

   int n_checks = 0;
   int n_pass   = 0;
   int n_done   = 0;

   expr_eval #(.WIDTH(16)) u_dut16 (
      .clk    (clk),
      .clr    (clr),
      .in_vld (in_vld),
      .in     (in_ch),
      .result (result16),
      .done   (done16),
      .err    (err16)
   );

   expr_eval #(.WIDTH(8)) u_dut8 (
      .clk    (clk),
      .clr    (clr),
      .in_vld (in_vld),
      .in     (in_ch),
      .result (result8),
      .done   (done8),
      .err    (err8)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it when it differs
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Present one character for one edge; outputs are sampled 1 ns later
   task automatic send(input byte c);
      in_vld = 1'b1;
      in_ch  = c;
      @(posedge clk);
      #1;
      in_vld = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   // One idle cycle after every character; tallies done pulses of the 8-bit DUT
   task automatic send_bubbled(input string s);
      for (int i = 0; i < s.len(); i++) begin
         send(s[i]);
         n_done += int'(done8);
         @(posedge clk);
         #1;
         n_done += int'(done8);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr    = 1'b1;
      in_vld = 1'b0;
      in_ch  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("reset_result16", result16, 0);
      check("reset_result8",  result8,  0);
      check("reset_done",     done16,   0);
      check("reset_err",      err16,    0);
      clr = 1'b0;
      idle();

      // precedence
      send_str("1+2*3=");
      check("prec_result", result16, 7);
      check("prec_done",   done16,   1);
      check("prec_err",    err16,    0);
      idle();
      check("prec_done_drop", done16,   0);
      check("prec_hold",      result16, 7);

      // back-to-back expressions
      send_str("2*3*4+5=");
      check("b2b_first_result", result16, 29);
      check("b2b_first_done",   done16,   1);
      send("9");
      check("b2b_gap_done",     done16,   0);
      send("=");
      check("b2b_second_result", result16, 9);
      check("b2b_second_done",   done16,   1);
      check("b2b_second_err",    err16,    0);

      // malformed streams, each after a valid result of 7
      send_str("1+2*3=");
      send_str("1++2=");
      check("dblop_done",   done16,   1);
      check("dblop_err",    err16,    1);
      check("dblop_result", result16, 7);
      send_str("1+2*3=");
      send_str("=");
      check("empty_done",   done16,   1);
      check("empty_err",    err16,    1);
      check("empty_result", result16, 7);
      send_str("1+2*3=");
      send_str("12=");
      check("multidig_done",   done16,   1);
      check("multidig_err",    err16,    1);
      check("multidig_result", result16, 7);
      idle();
      check("err_drop", err16, 0);

      // wrap-around: 6561 mod 256 = 161
      send_str("9*9*9*9=");
      check("wrap8_result",  result8,  161);
      check("wrap16_result", result16, 6561);
      check("wrap8_err",     err8,     0);
      idle();
      n_done = 0;
      send_bubbled("9*9*9*9=");
      check("bubble_result", result8, 161);
      check("bubble_pulses", n_done,  1);

      // asynchronous clear mid-expression
      send_str("1+2");
      clr = 1'b1;
      #1;
      check("clr_result16", result16, 0);
      check("clr_result8",  result8,  0);
      check("clr_done",     done16,   0);
      check("clr_err",      err16,    0);
      @(posedge clk);
      #1;
      clr = 1'b0;
      send_str("3=");
      check("post_clr_result", result16, 3);
      check("post_clr_done",   done16,   1);
      check("post_clr_err",    err16,    0);

      // subtraction, legal only with the option enabled
      send_str("1-2*3=");
      check("sub_done", done16, 1);
`ifdef EXPR_SUB_EN
      check("sub_err",      err16,    0);
      check("sub_result16", result16, 32'h0000_FFFB);
      check("sub_result8",  result8,  32'h0000_00FB);
`else
      check("sub_err",      err16,    1);
      check("sub_result16", result16, 3);
`endif
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/expr_eval.md
# expr_eval

Downstream consumer of the ASCII expression-recognizer stage: it takes the same byte stream of single-digit operands and operators and computes the expression's value with `*` binding tighter than `+`. It presents a registered result and a one-cycle completion strobe when the terminator `=` arrives. Syntax errors are flagged, never silently evaluated.

## Interface
- `WIDTH`, default 16: result and accumulator width; all arithmetic is modulo 2^WIDTH.
- `clk` input 1: single clock, rising edge.
- `clr` input 1: asynchronous, active-high reset.
- `in_vld` input 1: when high, `in` is consumed on this rising edge; when low, the block holds all state.
- `in` input 8: ASCII character. Legal values are `0`..`9`, `+`, `*` and `=`, plus `-` when `EXPR_SUB_EN` is defined.
- `result` output WIDTH: value of the last terminated expression.
- `done` output 1: one-cycle pulse on expression termination, whether the expression was valid or erroneous.
- `err` output 1: qualifies `done`; high in the same cycle as `done` if the terminated expression was malformed.

## Operation
- Internal registers:
  - `sum`: completed terms.
  - `prod`: current term.
  - `neg`: sign of the current term, used only with `EXPR_SUB_EN`.
  - `state`.
- `S_OPND`, expecting a digit (reset state):
  - digit d: if the previous operator was `*`, `prod <= prod*d`; otherwise `prod <= d`. Go to `S_OPTR`.
  - any other character: go to `S_ERR`.
  - exception: `=` goes directly to the error termination described under `S_ERR` (covers both an empty expression and a trailing operator).
- `S_OPTR`, expecting an operator:
  - `*`: mark the pending multiply, go to `S_OPND`.
  - `+`: `sum <= sum + prod`, clear the multiply mark, go to `S_OPND`.
  - `=`:
    - `result <= sum + prod`
    - `done=1`, `err=0`
    - clear `sum`, `prod` and the multiply mark
    - go to `S_OPND`.
  - digit or any unknown byte: go to `S_ERR`.
- `S_ERR`:
  - every character except `=` is ignored.
  - `=`: pulse `done=1` with `err=1`, clear `sum` and `prod`, go to `S_OPND`. `result` is unchanged.
- Arithmetic: digit value is `in - 8'h30`, zero-extended. Products and sums truncate to WIDTH bits, with no overflow flag.

## Timing
- Reset values: `result=0`, `done=0`, `err=0`, `state=S_OPND`, `sum=0`, `prod=0`.
- Latency: `done`, `err` and `result` update on the same edge that accepts `=`, so they are visible in the cycle after `=` is presented.
- `done` and `err` are high for exactly one cycle, then return to 0. `result` holds until the next valid termination.
- `in_vld=0` cycles are bubbles: no state change, and `done` still drops after one cycle.
- A new expression may begin in the cycle immediately after `=`, giving back-to-back expressions with no gap.
- `clr` asserted mid-expression discards partial state immediately and drives all outputs to their reset values, including `result`.
- Only one character is consumed per cycle, so no simultaneous-event cases exist beyond `clr`, which has priority.

## Configuration
- `EXPR_SUB_EN` defined:
  - `-` is a legal operator in `S_OPTR`.
  - On `-`: add the signed current term into `sum`, then set `neg=1`. The term is added as `+prod`, or subtracted as `-prod` if `neg` was set.
  - On `+`: clear `neg`.
  - `=` folds the signed current term into `sum`.
  - Results are two's complement modulo 2^WIDTH.
- `EXPR_SUB_EN` undefined: `-` is an unknown byte and goes to `S_ERR`. The `neg` register is not instantiated.

## Structure
- Package `expr_pkg` holds:
  - state enum `S_OPND`, `S_OPTR`, `S_ERR`.
  - ASCII constants for `0`, `9`, `+`, `*`, `-`, `=`.
  - char-class enum `C_DIGIT`, `C_ADD`, `C_MUL`, `C_SUB`, `C_EQ`, `C_BAD`.
- Sub-module `expr_char_class`: combinational decoder from `in` to char class plus 4-bit digit value. Its `C_SUB` output is gated by `EXPR_SUB_EN`.
- Top level contains the FSM and accumulators.

## Test plan
- `1+2*3=`, WIDTH=16, `in_vld` held high → `result=7`, one-cycle `done=1` with `err=0` in the cycle after `=`.
- `2*3*4+5=` immediately followed by `9=` → first `result=29`, next `result=9`, two separate `done` pulses.
- Malformed streams, each checked separately, starting after a prior `result=7`:
  - `1++2=` → `done=1`, `err=1`, `result` stays 7.
  - `=` alone → `done=1`, `err=1`, `result` stays 7.
  - `12=` → `done=1`, `err=1`, `result` stays 7.
- WIDTH=8, `9*9*9*9=` → `result=161` (6561 mod 256). Insert `in_vld=0` bubbles between characters: same result, `done` pulses once.
- `1+2` then `clr` pulsed for one cycle, then `3=` → all outputs 0 during `clr`, final `result=3`.
- With `EXPR_SUB_EN`, WIDTH=16: `1-2*3=` → `result=16'hFFFB`. Without the macro, the same stream → `err=1`.
